// File: rtl/di_ei_lut.sv
// Per-iteration CORDIC elementary constant e_i for circular, linear and hyperbolic modes,
// held as 30-fraction-bit tables, rounded to the output format and registered once.
module di_ei_lut #(
  parameter int WHOLE_BIT_WIDTH = 2,
  parameter int BIT_WIDTH       = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           count_in,
  input  logic [1:0]           coordinate_system_in,
  output logic [BIT_WIDTH-1:0] di_ei_output_out
);

  localparam int FRAC  = BIT_WIDTH - WHOLE_BIT_WIDTH;
  localparam int SHIFT = 30 - FRAC;
  // Half an output LSB in table units; collapses to 0 when no bits are dropped.
  localparam logic [32:0] HALF = (33'd1 << SHIFT) >> 1;

  typedef enum logic [1:0] {
    COORD_LIN  = 2'b00,
    COORD_CIRC = 2'b01,
    COORD_RSVD = 2'b10,
    COORD_HYP  = 2'b11
  } coord_e;

  // atan(2^-i) * 2^30, rounded to nearest
  function automatic logic [31:0] circ_entry(input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      5'd0:  v = 32'd843314857;
      5'd1:  v = 32'd497837829;
      5'd2:  v = 32'd263043837;
      5'd3:  v = 32'd133525159;
      5'd4:  v = 32'd67021687;
      5'd5:  v = 32'd33543516;
      5'd6:  v = 32'd16775851;
      5'd7:  v = 32'd8388437;
      5'd8:  v = 32'd4194283;
      5'd9:  v = 32'd2097149;
      5'd10: v = 32'd1048576;
      5'd11: v = 32'd524288;
      5'd12: v = 32'd262144;
      5'd13: v = 32'd131072;
      5'd14: v = 32'd65536;
      5'd15: v = 32'd32768;
      5'd16: v = 32'd16384;
      5'd17: v = 32'd8192;
      5'd18: v = 32'd4096;
      5'd19: v = 32'd2048;
      5'd20: v = 32'd1024;
      5'd21: v = 32'd512;
      5'd22: v = 32'd256;
      5'd23: v = 32'd128;
      5'd24: v = 32'd64;
      5'd25: v = 32'd32;
      5'd26: v = 32'd16;
      5'd27: v = 32'd8;
      5'd28: v = 32'd4;
      5'd29: v = 32'd2;
      5'd30: v = 32'd1;
      5'd31: v = 32'd0;
    endcase
    return v;
  endfunction

  // 2^-i * 2^30; the i=31 entry is an exact half and rounds up
  function automatic logic [31:0] lin_entry(input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      5'd0:  v = 32'd1073741824;
      5'd1:  v = 32'd536870912;
      5'd2:  v = 32'd268435456;
      5'd3:  v = 32'd134217728;
      5'd4:  v = 32'd67108864;
      5'd5:  v = 32'd33554432;
      5'd6:  v = 32'd16777216;
      5'd7:  v = 32'd8388608;
      5'd8:  v = 32'd4194304;
      5'd9:  v = 32'd2097152;
      5'd10: v = 32'd1048576;
      5'd11: v = 32'd524288;
      5'd12: v = 32'd262144;
      5'd13: v = 32'd131072;
      5'd14: v = 32'd65536;
      5'd15: v = 32'd32768;
      5'd16: v = 32'd16384;
      5'd17: v = 32'd8192;
      5'd18: v = 32'd4096;
      5'd19: v = 32'd2048;
      5'd20: v = 32'd1024;
      5'd21: v = 32'd512;
      5'd22: v = 32'd256;
      5'd23: v = 32'd128;
      5'd24: v = 32'd64;
      5'd25: v = 32'd32;
      5'd26: v = 32'd16;
      5'd27: v = 32'd8;
      5'd28: v = 32'd4;
      5'd29: v = 32'd2;
      5'd30: v = 32'd1;
      5'd31: v = 32'd1;
    endcase
    return v;
  endfunction

  // atanh(2^-i) * 2^30; i=0 is unused by hyperbolic iterations and reads 0
  function automatic logic [31:0] hyp_entry(input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      5'd0:  v = 32'd0;
      5'd1:  v = 32'd589812981;
      5'd2:  v = 32'd274247419;
      5'd3:  v = 32'd134923406;
      5'd4:  v = 32'd67196451;
      5'd5:  v = 32'd33565361;
      5'd6:  v = 32'd16778582;
      5'd7:  v = 32'd8388779;
      5'd8:  v = 32'd4194325;
      5'd9:  v = 32'd2097155;
      5'd10: v = 32'd1048576;
      5'd11: v = 32'd524288;
      5'd12: v = 32'd262144;
      5'd13: v = 32'd131072;
      5'd14: v = 32'd65536;
      5'd15: v = 32'd32768;
      5'd16: v = 32'd16384;
      5'd17: v = 32'd8192;
      5'd18: v = 32'd4096;
      5'd19: v = 32'd2048;
      5'd20: v = 32'd1024;
      5'd21: v = 32'd512;
      5'd22: v = 32'd256;
      5'd23: v = 32'd128;
      5'd24: v = 32'd64;
      5'd25: v = 32'd32;
      5'd26: v = 32'd16;
      5'd27: v = 32'd8;
      5'd28: v = 32'd4;
      5'd29: v = 32'd2;
      5'd30: v = 32'd1;
      5'd31: v = 32'd1;
    endcase
    return v;
  endfunction

  coord_e                coord_w;
  logic [31:0]           table_w;
  logic [32:0]           sum_w;
  logic [32:0]           quant_w;
  logic [BIT_WIDTH-1:0]  di_ei_d;
  logic [BIT_WIDTH-1:0]  di_ei_q;

  assign coord_w = coord_e'(coordinate_system_in);

  // NOTE: every signal written in always_comb is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    table_w = 32'd0;
    if (!count_in[5]) begin
      case (coord_w)
        COORD_CIRC: table_w = circ_entry(count_in[4:0]);
        COORD_LIN:  table_w = lin_entry(count_in[4:0]);
        COORD_HYP:  table_w = hyp_entry(count_in[4:0]);
        default:    table_w = 32'd0;
      endcase
    end
  end

  // Round half up to FRAC bits; the result never exceeds 1.0, so the sign bit stays 0.
  always_comb begin
    sum_w   = {1'b0, table_w} + HALF;
    quant_w = sum_w >> SHIFT;
    di_ei_d = BIT_WIDTH'(quant_w);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      di_ei_q <= '0;
    end else begin
      di_ei_q <= di_ei_d;
    end
  end

  assign di_ei_output_out = di_ei_q;

endmodule

// File: tb/tb_di_ei_lut.sv
// Directed, table-driven bench for di_ei_lut at the default Q2.4 output format.
module tb_di_ei_lut;

  logic       clk;
  logic       rst_n;
  logic [5:0] count_in;
  logic [1:0] coordinate_system_in;
  logic [5:0] di_ei_output_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] m;
    logic [5:0] cnt;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  di_ei_lut #(
    .WHOLE_BIT_WIDTH(2),
    .BIT_WIDTH      (6)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .count_in            (count_in),
    .coordinate_system_in(coordinate_system_in),
    .di_ei_output_out    (di_ei_output_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input int cnt, input logic [5:0] exp);
    vec_t v;
    v.m   = m;
    v.cnt = 6'(cnt);
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // hyperbolic sweep
    add(2'b11, 0, 6'b000000); add(2'b11, 1, 6'b001001); add(2'b11, 2, 6'b000100);
    add(2'b11, 3, 6'b000010); add(2'b11, 4, 6'b000001); add(2'b11, 5, 6'b000001);
    add(2'b11, 6, 6'b000000);
    // circular sweep
    add(2'b01, 0, 6'b001101); add(2'b01, 1, 6'b000111); add(2'b01, 2, 6'b000100);
    add(2'b01, 3, 6'b000010); add(2'b01, 4, 6'b000001); add(2'b01, 5, 6'b000000);
    add(2'b01, 6, 6'b000000);
    // linear sweep, i=5 is the exact half-LSB case
    add(2'b00, 0, 6'b010000); add(2'b00, 1, 6'b001000); add(2'b00, 2, 6'b000100);
    add(2'b00, 3, 6'b000010); add(2'b00, 4, 6'b000001); add(2'b00, 5, 6'b000001);
    add(2'b00, 6, 6'b000000);
    // boundaries, interleaved with non-zero entries so a stuck output is visible
    for (int m = 0; m < 4; m++) begin
      add(2'(m), 31, 6'b000000);
      add(2'b00, 0, 6'b010000);
      add(2'(m), 32, 6'b000000);
      add(2'b01, 1, 6'b000111);
      add(2'(m), 63, 6'b000000);
      add(2'b11, 1, 6'b001001);
    end
    add(2'b10, 0, 6'b000000);
    add(2'b00, 0, 6'b010000);
    add(2'b10, 1, 6'b000000);
    add(2'b01, 32, 6'b000000);
    add(2'b00, 33, 6'b000000);

    // reset held: clock runs, output must stay 0
    rst_n                = 1'b0;
    count_in             = 6'd1;
    coordinate_system_in = 2'b01;
    #1;
    check("reset_async", di_ei_output_out, 6'b000000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", di_ei_output_out, 6'b000000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", di_ei_output_out, 6'b000111);

    foreach (vecs[k]) begin
      count_in             = vecs[k].cnt;
      coordinate_system_in = vecs[k].m;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_m%b_i%0d", k, vecs[k].m, vecs[k].cnt), di_ei_output_out, vecs[k].exp);
    end

    // inputs changed between edges are not seen until the next rising edge
    count_in             = 6'd0;
    coordinate_system_in = 2'b01;
    @(posedge clk);
    #1;
    check("hold_load", di_ei_output_out, 6'b001101);
    count_in             = 6'd1;
    coordinate_system_in = 2'b00;
    #2;
    check("hold_between_edges", di_ei_output_out, 6'b001101);
    @(posedge clk);
    #1;
    check("hold_next_edge", di_ei_output_out, 6'b001000);

    // asynchronous reset between edges while holding 13
    count_in             = 6'd0;
    coordinate_system_in = 2'b01;
    @(posedge clk);
    #1;
    check("async_pre", di_ei_output_out, 6'b001101);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", di_ei_output_out, 6'b000000);
    @(posedge clk);
    #1;
    check("async_held", di_ei_output_out, 6'b000000);
    #2;
    rst_n = 1'b1;
    count_in             = 6'd2;
    coordinate_system_in = 2'b11;
    #1;
    check("async_release_no_edge", di_ei_output_out, 6'b000000);
    @(posedge clk);
    #1;
    check("async_first_edge", di_ei_output_out, 6'b000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
